// File: rtl/mips_isa_pkg.sv
// Shared MIPS subset definitions: mnemonic codes, opcode/funct values,
// instruction field positions and the loader FSM state encoding.
package mips_isa_pkg;

    localparam logic [3:0] MN_ADD     = 4'd0;
    localparam logic [3:0] MN_SUB     = 4'd1;
    localparam logic [3:0] MN_AND     = 4'd2;
    localparam logic [3:0] MN_OR      = 4'd3;
    localparam logic [3:0] MN_XOR     = 4'd4;
    localparam logic [3:0] MN_SLT     = 4'd5;
    localparam logic [3:0] MN_J       = 4'd6;
    localparam logic [3:0] MN_SW      = 4'd7;
    localparam logic [3:0] MN_LW      = 4'd8;
    localparam logic [3:0] MN_ADDI    = 4'd9;
    localparam logic [3:0] MN_SLTI    = 4'd10;
    localparam logic [3:0] MN_ANDI    = 4'd11;
    localparam logic [3:0] MN_ORI     = 4'd12;
    localparam logic [3:0] MN_BEQ     = 4'd13;
    localparam logic [3:0] MN_BNE     = 4'd14;
    localparam logic [3:0] MN_ILLEGAL = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_LSB   = 0;
    localparam int TGT_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_BAD = 2'd3
    } fmt_e;

    // Mnemonic codes are grouped by format, so ranges classify them.
    function automatic fmt_e mnem_fmt(input logic [3:0] m);
        if (m <= MN_SLT) return FMT_R;
        if (m == MN_J)   return FMT_J;
        if (m <= MN_BNE) return FMT_I;
        return FMT_BAD;
    endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational encoder: symbolic request -> 32-bit MIPS word plus legality.
module instr_encode
    import mips_isa_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    logic [5:0] op;
    logic [5:0] funct;
    fmt_e       fmt;

    always_comb begin
        op    = OP_RTYPE;
        funct = '0;
        case (mnem)
            MN_ADD:  funct = FN_ADD;
            MN_SUB:  funct = FN_SUB;
            MN_AND:  funct = FN_AND;
            MN_OR:   funct = FN_OR;
            MN_XOR:  funct = FN_XOR;
            MN_SLT:  funct = FN_SLT;
            MN_J:    op = OP_J;
            MN_SW:   op = OP_SW;
            MN_LW:   op = OP_LW;
            MN_ADDI: op = OP_ADDI;
            MN_SLTI: op = OP_SLTI;
            MN_ANDI: op = OP_ANDI;
            MN_ORI:  op = OP_ORI;
            MN_BEQ:  op = OP_BEQ;
            MN_BNE:  op = OP_BNE;
            default: op = OP_RTYPE;
        endcase
    end

    // Fields a format does not use stay zero whatever the request carries.
    always_comb begin
        fmt   = mnem_fmt(mnem);
        legal = (fmt != FMT_BAD);
        word  = '0;
        case (fmt)
            FMT_R: begin
                word[RS_LSB +: 5]    = rs;
                word[RT_LSB +: 5]    = rt;
                word[RD_LSB +: 5]    = rd;
                word[FUNCT_LSB +: 6] = funct;
            end
            FMT_I: begin
                word[OP_LSB +: 6]   = op;
                word[RS_LSB +: 5]   = rs;
                word[RT_LSB +: 5]   = rt;
                word[IMM_LSB +: 16] = imm;
            end
            FMT_J: begin
                word[OP_LSB +: 6]   = op;
                word[TGT_LSB +: 26] = target;
            end
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Load-session FSM: accepts symbolic requests, encodes them and writes the
// words to consecutive instruction-memory addresses, one word per 2 cycles.
module instr_encoder_loader
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 8
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic [31:0]       enc_word;
    logic              enc_legal;

    instr_encode u_encode (
        .mnem   (in_mnem),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .imm    (in_imm),
        .target (in_target),
        .word   (enc_word),
        .legal  (enc_legal)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        count_d     = count_q;
        full_d      = full_q;
        err_d       = err_q;
        in_ready    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    ptr_d   = base_addr;
                    count_d = '0;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                // finish wins over a pending request; no handshake that cycle.
                in_ready = !finish;
                if (finish) begin
                    state_d = ST_DONE;
                end else if (in_valid) begin
                    if (enc_legal) begin
                        mem_wdata_d = enc_word;
                        mem_addr_d  = ptr_q;
                        state_d     = ST_WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                count_d = count_q + CNT_ONE;
                if (ptr_q == LAST_ADDR) begin
                    full_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    ptr_d   = ptr_q + PTR_ONE;
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            count_q     <= count_d;
            full_q      <= full_d;
            err_q       <= err_d;
        end
    end

    // Gating with rst keeps a write from landing while the session is torn down.
    assign mem_we    = (state_q == ST_WRITE) && !rst;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign count     = count_q;
    assign full      = full_q;
    assign err       = err_q;
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a wide (ADDR_W=8) and a tiny
// (ADDR_W=2) instance, each tracked by a session-level reference model.
module tb_instr_encoder_loader;

    typedef struct packed {
        logic        rst;
        logic        start;
        logic [7:0]  base;
        logic        finish;
        logic        valid;
        logic [3:0]  mnem;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] tgt;
    } drv_t;

    typedef struct {
        bit          acc;
        bit          wr;
        bit          endg;
        bit          full;
        bit          err;
        int          ptr;
        int          cnt;
        int          maddr;
        logic [31:0] mdata;
    } mdl_t;

    logic clk;
    drv_t drv [2];
    mdl_t m [2];

    logic [1:0]  rdy, we, busy, full, err, done;
    logic [7:0]  b_addr;
    logic [1:0]  s_addr;
    logic [8:0]  b_cnt;
    logic [2:0]  s_cnt;
    logic [31:0] wd [2];
    logic [31:0] ad [2];
    logic [31:0] cn [2];

    int checks = 0;
    int fails  = 0;
    bit armed  = 0;

    instr_encoder_loader #(.ADDR_W(8)) u_big (
        .clk(clk), .rst(drv[0].rst), .start(drv[0].start), .base_addr(drv[0].base),
        .finish(drv[0].finish), .in_valid(drv[0].valid), .in_ready(rdy[0]),
        .in_mnem(drv[0].mnem), .in_rs(drv[0].rs), .in_rt(drv[0].rt), .in_rd(drv[0].rd),
        .in_imm(drv[0].imm), .in_target(drv[0].tgt),
        .mem_we(we[0]), .mem_addr(b_addr), .mem_wdata(wd[0]), .busy(busy[0]),
        .count(b_cnt), .full(full[0]), .err(err[0]), .done(done[0])
    );

    instr_encoder_loader #(.ADDR_W(2)) u_small (
        .clk(clk), .rst(drv[1].rst), .start(drv[1].start), .base_addr(drv[1].base[1:0]),
        .finish(drv[1].finish), .in_valid(drv[1].valid), .in_ready(rdy[1]),
        .in_mnem(drv[1].mnem), .in_rs(drv[1].rs), .in_rt(drv[1].rt), .in_rd(drv[1].rd),
        .in_imm(drv[1].imm), .in_target(drv[1].tgt),
        .mem_we(we[1]), .mem_addr(s_addr), .mem_wdata(wd[1]), .busy(busy[1]),
        .count(s_cnt), .full(full[1]), .err(err[1]), .done(done[1])
    );

    assign ad[0] = 32'(b_addr);
    assign ad[1] = 32'(s_addr);
    assign cn[0] = 32'(b_cnt);
    assign cn[1] = 32'(s_cnt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoding straight from the instruction tables.
    function automatic logic [31:0] menc(input logic [3:0] mn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [15:0] imm, input logic [25:0] tg);
        logic [5:0] f;
        logic [5:0] op;
        f  = 6'h00;
        op = 6'h00;
        case (mn)
            4'd0: f = 6'h20;
            4'd1: f = 6'h22;
            4'd2: f = 6'h24;
            4'd3: f = 6'h25;
            4'd4: f = 6'h26;
            4'd5: f = 6'h2A;
            4'd7: op = 6'h2B;
            4'd8: op = 6'h23;
            4'd9: op = 6'h08;
            4'd10: op = 6'h0A;
            4'd11: op = 6'h0C;
            4'd12: op = 6'h0D;
            4'd13: op = 6'h04;
            4'd14: op = 6'h05;
            default: op = 6'h00;
        endcase
        if (mn <= 4'd5) return {6'h00, rs, rt, rd, 5'd0, f};
        if (mn == 4'd6) return {6'h02, tg};
        return {op, rs, rt, imm};
    endfunction

    function automatic mdl_t step(input mdl_t s, input drv_t d, input int aw);
        mdl_t n;
        n = s;
        if (d.rst) begin
            n.acc = 0; n.wr = 0; n.endg = 0; n.full = 0; n.err = 0;
            n.ptr = 0; n.cnt = 0; n.maddr = 0; n.mdata = '0;
        end else if (s.endg) begin
            n.endg = 0;
        end else if (s.wr) begin
            n.wr  = 0;
            n.cnt = s.cnt + 1;
            if (s.ptr == (1 << aw) - 1) begin
                n.full = 1; n.endg = 1;
            end else begin
                n.ptr = s.ptr + 1; n.acc = 1;
            end
        end else if (s.acc) begin
            if (d.finish) begin
                n.acc = 0; n.endg = 1;
            end else if (d.valid) begin
                if (d.mnem == 4'd15) n.err = 1;
                else begin
                    n.maddr = s.ptr;
                    n.mdata = menc(d.mnem, d.rs, d.rt, d.rd, d.imm, d.tgt);
                    n.wr = 1; n.acc = 0;
                end
            end
        end else if (d.start) begin
            n.acc = 1; n.ptr = int'(d.base) & ((1 << aw) - 1);
            n.cnt = 0; n.full = 0; n.err = 0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m[0] <= step(m[0], drv[0], 8);
        m[1] <= step(m[1], drv[1], 2);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input int w);
        mdl_t  e;
        drv_t  d;
        string p;
        e = m[w];
        d = drv[w];
        p = (w == 0) ? "big" : "small";
        chk({p, ".in_ready"},  32'(rdy[w]),  32'(e.acc && !d.finish));
        chk({p, ".mem_we"},    32'(we[w]),   32'(e.wr && !d.rst));
        chk({p, ".mem_addr"},  ad[w],        32'(e.maddr));
        chk({p, ".mem_wdata"}, wd[w],        e.mdata);
        chk({p, ".busy"},      32'(busy[w]), 32'(e.acc || e.wr || e.endg));
        chk({p, ".count"},     cn[w],        32'(e.cnt));
        chk({p, ".full"},      32'(full[w]), 32'(e.full));
        chk({p, ".err"},       32'(err[w]),  32'(e.err));
        chk({p, ".done"},      32'(done[w]), 32'(e.endg));
    endtask

    always @(negedge clk) begin
        if (armed) begin
            cmp(0);
            cmp(1);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_s(input int w, input logic [7:0] base);
        drv[w].start = 1'b1;
        drv[w].base  = base;
        cyc();
        drv[w].start = 1'b0;
    endtask

    // Offers one request; returns at the edge after the handshake (or after the bound).
    task automatic send(input int w, input logic [3:0] mn, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                        input logic [25:0] tg, input bit exp_acc, input string nm);
        bit acc;
        acc = 0;
        drv[w].mnem = mn; drv[w].rs = rs; drv[w].rt = rt; drv[w].rd = rd;
        drv[w].imm = imm; drv[w].tgt = tg; drv[w].valid = 1'b1;
        for (int i = 0; i < 8 && !acc; i++) begin
            @(negedge clk);
            if (rdy[w]) begin
                cyc();
                acc = 1;
            end
        end
        if (!acc) cyc();
        drv[w].valid = 1'b0;
        chk({nm, ".accepted"}, 32'(acc), 32'(exp_acc));
    endtask

    task automatic expect_we(input int w, input int a, input logic [31:0] dat, input string nm);
        @(negedge clk);
        chk({nm, ".we"},    32'(we[w]),  32'd1);
        chk({nm, ".addr"},  ad[w],       32'(a));
        chk({nm, ".data"},  wd[w],       dat);
        chk({nm, ".ready"}, 32'(rdy[w]), 32'd0);
        cyc();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        drv[0] = '0;
        drv[1] = '0;
        drv[0].rst = 1'b1;
        drv[1].rst = 1'b1;
        cyc();
        cyc();
        drv[0].rst = 1'b0;
        drv[1].rst = 1'b0;
        armed = 1;

        // Model pins against hand-encoded words.
        chk("pin.add", menc(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0), 32'h00221820);
        chk("pin.lw",  menc(4'd8, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0), 32'h8FA80004);
        chk("pin.j",   menc(4'd6, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010), 32'h08000010);

        @(negedge clk);
        chk("reset.busy",  32'(busy[0]), 32'd0);
        chk("reset.count", cn[0],        32'd0);
        chk("reset.ready", 32'(rdy[0]),  32'd0);
        cyc();

        // Session 1: four words from base 0.
        start_s(0, 8'h00);
        send(0, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1, "add");
        expect_we(0, 0, 32'h00221820, "add");
        send(0, 4'd8, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1, "lw");
        expect_we(0, 1, 32'h8FA80004, "lw");
        send(0, 4'd6, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 1, "j");
        expect_we(0, 2, 32'h08000010, "j");
        send(0, 4'd13, 5'd4, 5'd5, 5'd0, 16'hFFFF, 26'h0, 1, "beq");
        expect_we(0, 3, 32'h1085FFFF, "beq");
        @(negedge clk);
        chk("s1.count", cn[0], 32'd4);
        cyc();

        // Illegal mnemonic: no write, err sticky, pointer not advanced.
        send(0, 4'd15, 5'd1, 5'd1, 5'd1, 16'h1111, 26'h0, 1, "ill");
        @(negedge clk);
        chk("ill.we",  32'(we[0]),  32'd0);
        chk("ill.err", 32'(err[0]), 32'd1);
        cyc();
        send(0, 4'd12, 5'd3, 5'd7, 5'd0, 16'h00FF, 26'h0, 1, "ori");
        expect_we(0, 4, 32'h346700FF, "ori");

        // finish together with a valid request: finish wins.
        drv[0].finish = 1'b1;
        drv[0].valid  = 1'b1;
        drv[0].mnem   = 4'd0;
        @(negedge clk);
        chk("fin.ready", 32'(rdy[0]), 32'd0);
        cyc();
        drv[0].finish = 1'b0;
        drv[0].valid  = 1'b0;
        @(negedge clk);
        chk("fin.done", 32'(done[0]), 32'd1);
        chk("fin.we",   32'(we[0]),   32'd0);
        chk("fin.busy", 32'(busy[0]), 32'd1);
        cyc();
        @(negedge clk);
        chk("fin.done_off", 32'(done[0]), 32'd0);
        chk("fin.busy_off", 32'(busy[0]), 32'd0);
        chk("fin.count",    cn[0],        32'd5);
        chk("fin.err",      32'(err[0]),  32'd1);
        cyc();

        // start while busy is ignored.
        start_s(0, 8'h10);
        send(0, 4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1, "sub");
        drv[0].start = 1'b1;
        drv[0].base  = 8'h80;
        expect_we(0, 8'h10, 32'h00221822, "sub");
        send(0, 4'd5, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1, "slt");
        drv[0].start = 1'b0;
        expect_we(0, 8'h11, 32'h0085302A, "slt");

        // Reset in the middle of a write.
        send(0, 4'd9, 5'd2, 5'd3, 5'd0, 16'h8000, 26'h0, 1, "addi");
        drv[0].rst = 1'b1;
        @(negedge clk);
        chk("rstw.we", 32'(we[0]), 32'd0);
        cyc();
        drv[0].rst = 1'b0;
        @(negedge clk);
        chk("rstw.busy", 32'(busy[0]), 32'd0);
        chk("rstw.addr", ad[0],        32'd0);
        chk("rstw.data", wd[0],        32'd0);
        chk("rstw.cnt",  cn[0],        32'd0);
        cyc();
        start_s(0, 8'h20);
        send(0, 4'd11, 5'd9, 5'd10, 5'd0, 16'h1234, 26'h0, 1, "andi");
        expect_we(0, 8'h20, 32'h312A1234, "andi");

        // Tiny instance: memory fills at address 3, third request refused.
        start_s(1, 8'h02);
        send(1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1, "sm0");
        expect_we(1, 2, 32'h00221820, "sm0");
        send(1, 4'd3, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1, "sm1");
        expect_we(1, 3, 32'h00210825, "sm1");
        @(negedge clk);
        chk("sm.done",  32'(done[1]), 32'd1);
        chk("sm.full",  32'(full[1]), 32'd1);
        chk("sm.count", cn[1],        32'd2);
        cyc();
        send(1, 4'd2, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 0, "sm2");
        @(negedge clk);
        chk("sm.count_end", cn[1],        32'd2);
        chk("sm.full_end",  32'(full[1]), 32'd1);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
